// File: rtl/dmem_responder_if.sv
// Purpose: request/response bundle between the MEM-stage datapath and the data-memory responder.
// Latency: none (wires only).
// Backpressure: the responder holds req_ready low while an access is in flight.
//
// Signals: req_valid/req_ready handshake, req_addr (byte address), req_wr, req_size, req_wdata
// (right-justified), rsp_valid (one-cycle pulse), rsp_rdata (left-justified), rsp_err.
// master = datapath side, slave = responder side.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_wr, req_size, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wr, req_size, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Purpose: single-outstanding data-memory responder for the MEM stage; byte/half/word big-endian lanes, RMW for sub-word stores.
// Latency: load and word store respond LATENCY cycles after acceptance, sub-word store 2*LATENCY, alignment error 1.
// Backpressure: req_ready is low from acceptance until the response cycle; requests offered while busy are ignored.
//
// Ports: clk; reset (synchronous, active-high); bus (dmem_responder_if.slave) carrying req_* and rsp_*.
// Parameters: ADDR_WIDTH = word-index bits of the backing array, LATENCY = array access cycles (>= 1).
// Build option DMEM_RESP_ALIGN_CHECK_EN: when defined, misaligned half/word and reserved size 2'b10 respond
// with rsp_err and touch no memory; when undefined, low address bits are masked and size 2'b10 acts as word.
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, RMW_RD, RMW_WR, ERR} stateT;

    // Backing store; deliberately not cleared by reset.
    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    stateT                 stateQ, stateD;
    logic [CNT_W-1:0]      cntQ, cntD;
    logic [ADDR_WIDTH-1:0] idxQ;
    logic [1:0]            offQ;
    logic [1:0]            sizeQ;
    logic [31:0]           wdataQ;
    logic [31:0]           mergeQ;
    logic                  rspValidQ;
    logic [31:0]           rspRdataQ;

    logic        ready;
    logic        accept;
    logic        cntDone;
    logic        rspFire;
    logic        memWe;
    logic [1:0]  inSize;
    logic [1:0]  inOff;
    logic        inErr;
    logic [31:0] memWord;
    logic [31:0] memWdata;
    logic [31:0] laneWord;
    logic [31:0] laneMask;
    logic [31:0] laneData;
    logic [31:0] mergedWord;
    logic        unusedAddrBits;

    // Address bits above the word index wrap and are ignored.
    assign unusedAddrBits = ^bus.req_addr[31:ADDR_WIDTH+2];

    assign ready   = (stateQ == IDLE) && !reset;
    assign accept  = bus.req_valid && ready;
    assign cntDone = (cntQ == '0);
    assign memWord = mem[idxQ];

    // Request decode: alignment check or alignment masking depending on build.
    always_comb begin
        inSize = bus.req_size;
        inOff  = bus.req_addr[1:0];
        inErr  = 1'b0;
`ifdef DMEM_RESP_ALIGN_CHECK_EN
        case (bus.req_size)
            2'b01:   inErr = bus.req_addr[0];
            2'b10:   inErr = 1'b1;
            2'b11:   inErr = (bus.req_addr[1:0] != 2'b00);
            default: inErr = 1'b0;
        endcase
`else
        if (bus.req_size == 2'b10) begin
            inSize = 2'b11;
        end
        if (inSize == 2'b01) begin
            inOff = {bus.req_addr[1], 1'b0};
        end else if (inSize == 2'b11) begin
            inOff = 2'b00;
        end
`endif
    end

    // Next-state, counter and completion strobes.
    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        rspFire = 1'b0;
        memWe   = 1'b0;
        case (stateQ)
            IDLE: begin
                if (accept) begin
                    cntD = CNT_LOAD;
                    if (inErr) begin
                        stateD = ERR;
                        cntD   = '0;
                    end else if (!bus.req_wr) begin
                        stateD = RD_WAIT;
                    end else if (inSize == 2'b11) begin
                        stateD = WR_WAIT;
                    end else begin
                        stateD = RMW_RD;
                    end
                end
            end
            RD_WAIT, WR_WAIT, RMW_WR: begin
                if (cntDone) begin
                    stateD  = IDLE;
                    rspFire = 1'b1;
                    // A write must never land on an edge where reset is sampled high.
                    memWe   = (stateQ != RD_WAIT) && !reset;
                end else begin
                    cntD = cntQ - 1'b1;
                end
            end
            RMW_RD: begin
                if (cntDone) begin
                    stateD = RMW_WR;
                    cntD   = CNT_LOAD;
                end else begin
                    cntD = cntQ - 1'b1;
                end
            end
            ERR: begin
                stateD  = IDLE;
                rspFire = 1'b1;
            end
            default: stateD = IDLE;
        endcase
    end

    // Lane datapath. Shifting left by the byte offset puts the addressed lane at [31:*]
    // (big-endian), and the store mask/data are the same lane shifted right into place.
    always_comb begin
        laneWord = memWord << {offQ, 3'b000};
        case (sizeQ)
            2'b00: begin
                laneWord = {laneWord[31:24], 24'h0};
                laneMask = 32'hFF00_0000 >> {offQ, 3'b000};
                laneData = {wdataQ[7:0], 24'h0} >> {offQ, 3'b000};
            end
            2'b01: begin
                laneWord = {laneWord[31:16], 16'h0};
                laneMask = 32'hFFFF_0000 >> {offQ, 3'b000};
                laneData = {wdataQ[15:0], 16'h0} >> {offQ, 3'b000};
            end
            default: begin
                laneMask = 32'hFFFF_FFFF;
                laneData = wdataQ;
            end
        endcase
        mergedWord = (memWord & ~laneMask) | (laneData & laneMask);
        memWdata   = (stateQ == RMW_WR) ? mergeQ : wdataQ;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= IDLE;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rspValidQ <= 1'b0;
            rspRdataQ <= '0;
        end else begin
            rspValidQ <= rspFire;
            if (rspFire) begin
                rspRdataQ <= (stateQ == RD_WAIT) ? laneWord : 32'h0;
            end
        end
    end

    // Capture and merge registers need no reset: they are only consumed after a fresh acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            idxQ   <= bus.req_addr[ADDR_WIDTH+1:2];
            offQ   <= inOff;
            sizeQ  <= inSize;
            wdataQ <= bus.req_wdata;
        end
        if ((stateQ == RMW_RD) && cntDone && !reset) begin
            mergeQ <= mergedWord;
        end
    end

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[idxQ] <= memWdata;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rspValidQ;
    assign bus.rsp_rdata = rspRdataQ;

`ifdef DMEM_RESP_ALIGN_CHECK_EN
    logic rspErrQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            rspErrQ <= 1'b0;
        end else if (rspFire) begin
            rspErrQ <= (stateQ == ERR);
        end
    end

    assign bus.rsp_err = rspErrQ;
`else
    assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    localparam int AW     = 10;
    localparam int LAT    = 2;
    localparam int WINDOW = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   testsRun    = 0;
    int   testsFailed = 0;
    logic [31:0] model [0:(1<<AW)-1];

    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference: memory as bytes, big-endian; returns expected data, error flag and response latency.
    task automatic model_access(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rdata,
                                output logic err, output int lat);
        int idx;
        int nbytes;
        int off;
        logic [7:0] b [4];
        idx   = int'((addr / 4) % (1 << AW));
        rdata = 32'h0;
        err   = 1'b0;
        lat   = LAT;
        case (size)
            2'b00:   nbytes = 1;
            2'b01:   nbytes = 2;
            default: nbytes = 4;
        endcase
        off = int'(addr % 4);
`ifdef DMEM_RESP_ALIGN_CHECK_EN
        if (size == 2'b10 || (off % nbytes) != 0) begin
            err = 1'b1;
            lat = 1;
            return;
        end
`endif
        off = off - (off % nbytes);
        for (int i = 0; i < 4; i++) b[i] = model[idx][31-8*i -: 8];
        if (!wr) begin
            for (int i = 0; i < nbytes; i++) rdata[31-8*i -: 8] = b[off+i];
        end else begin
            for (int i = 0; i < nbytes; i++) b[off+i] = wdata[8*(nbytes-1-i) +: 8];
            for (int i = 0; i < 4; i++) model[idx][31-8*i -: 8] = b[i];
            if (nbytes != 4) lat = 2 * LAT;
        end
    endtask

    task automatic scramble();
        bus.req_addr  = $urandom;
        bus.req_wr    = 1'($urandom_range(1));
        bus.req_size  = 2'($urandom_range(3));
        bus.req_wdata = $urandom;
    endtask

    // Issue one request starting #1 after an edge; lat = edges from acceptance to rsp_valid, -1 on timeout.
    task automatic do_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat);
        int guard = 0;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        scramble();
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (bus.rsp_valid !== 1'b1 && lat < 40);
        if (bus.rsp_valid !== 1'b1 || guard >= 50) lat = -1;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 1'b1;
        scramble();
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if (bus.req_ready !== 1'b0) begin testsFailed++; $display("FAIL reset_ready: got %b expected 0", bus.req_ready); end
        testsRun++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
            testsFailed++;
            $display("FAIL reset_outputs: got valid=%b err=%b rdata=%h expected 0/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        bus.req_valid = 1'b0;
        reset = 1'b0;
        #1;
        testsRun++;
        if (bus.req_ready !== 1'b1) begin testsFailed++; $display("FAIL reset_release_ready: got %b expected 1", bus.req_ready); end
    endtask

    task automatic test_word_roundtrip();
        logic [31:0] rd, erd; logic er, eer; int lat, elat;
        model_access(1'b1, 2'b11, 32'h10, 32'hDEADBEEF, erd, eer, elat);
        do_req(1'b1, 2'b11, 32'h10, 32'hDEADBEEF, rd, er, lat);
        testsRun++;
        if (lat !== LAT || er !== 1'b0 || rd !== 32'h0) begin
            testsFailed++; $display("FAIL word_store: got lat=%0d err=%b rdata=%h expected lat=%0d err=0 rdata=0", lat, er, rd, LAT);
        end
        do_req(1'b0, 2'b11, 32'h10, 32'h0, rd, er, lat);
        testsRun++;
        if (lat !== LAT || rd !== 32'hDEADBEEF) begin
            testsFailed++; $display("FAIL word_load: got lat=%0d rdata=%h expected lat=%0d rdata=deadbeef", lat, rd, LAT);
        end
    endtask

    task automatic test_byte_rmw();
        logic [31:0] rd, erd; logic er, eer; int lat, elat;
        model_access(1'b1, 2'b00, 32'h11, 32'h000000AB, erd, eer, elat);
        do_req(1'b1, 2'b00, 32'h11, 32'h000000AB, rd, er, lat);
        testsRun++;
        if (lat !== 2 * LAT || er !== 1'b0) begin
            testsFailed++; $display("FAIL byte_store_lat: got lat=%0d err=%b expected lat=%0d err=0", lat, er, 2 * LAT);
        end
        do_req(1'b0, 2'b11, 32'h10, 32'h0, rd, er, lat);
        testsRun++;
        if (rd !== 32'hDEABBEEF) begin testsFailed++; $display("FAIL byte_merge: got %h expected deabbeef", rd); end
        do_req(1'b0, 2'b00, 32'h11, 32'h0, rd, er, lat);
        testsRun++;
        if (lat !== LAT || rd !== 32'hAB000000) begin
            testsFailed++; $display("FAIL byte_load: got lat=%0d rdata=%h expected lat=%0d rdata=ab000000", lat, rd, LAT);
        end
    endtask

    task automatic test_half_lanes();
        logic [31:0] rd, erd; logic er, eer; int lat, elat;
        do_req(1'b0, 2'b01, 32'h12, 32'h0, rd, er, lat);
        testsRun++;
        if (rd !== 32'hBEEF0000) begin testsFailed++; $display("FAIL half_load: got %h expected beef0000", rd); end
        model_access(1'b1, 2'b01, 32'h10, 32'h00001234, erd, eer, elat);
        do_req(1'b1, 2'b01, 32'h10, 32'h00001234, rd, er, lat);
        testsRun++;
        if (lat !== 2 * LAT) begin testsFailed++; $display("FAIL half_store_lat: got %0d expected %0d", lat, 2 * LAT); end
        do_req(1'b0, 2'b11, 32'h10, 32'h0, rd, er, lat);
        testsRun++;
        if (rd !== 32'h1234BEEF) begin testsFailed++; $display("FAIL half_merge: got %h expected 1234beef", rd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, 2'b11, 32'h13, 32'h0, rd, er, lat);
`ifdef DMEM_RESP_ALIGN_CHECK_EN
        testsRun++;
        if (er !== 1'b1 || lat !== 1) begin
            testsFailed++; $display("FAIL misaligned_err: got err=%b lat=%0d expected err=1 lat=1", er, lat);
        end
        do_req(1'b1, 2'b01, 32'h11, 32'h0000FFFF, rd, er, lat);
        testsRun++;
        if (er !== 1'b1 || lat !== 1) begin
            testsFailed++; $display("FAIL misaligned_store_err: got err=%b lat=%0d expected err=1 lat=1", er, lat);
        end
        do_req(1'b0, 2'b11, 32'h10, 32'h0, rd, er, lat);
        testsRun++;
        if (rd !== 32'h1234BEEF || er !== 1'b0) begin
            testsFailed++; $display("FAIL misaligned_untouched: got %h err=%b expected 1234beef err=0", rd, er);
        end
`else
        testsRun++;
        if (er !== 1'b0 || lat !== LAT || rd !== 32'h1234BEEF) begin
            testsFailed++; $display("FAIL misaligned_masked: got err=%b lat=%0d rdata=%h expected 0/%0d/1234beef", er, lat, rd, LAT);
        end
`endif
    endtask

    task automatic test_reset_mid_rmw();
        logic [31:0] rd; logic er; int lat;
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h00000055;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        testsRun++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.req_ready !== 1'b0) begin
            testsFailed++;
            $display("FAIL rmw_reset_outputs: got valid=%b err=%b rdata=%h ready=%b expected all 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready);
        end
        reset = 1'b0;
        #1;
        testsRun++;
        if (bus.req_ready !== 1'b1) begin testsFailed++; $display("FAIL rmw_reset_ready: got %b expected 1", bus.req_ready); end
        do_req(1'b0, 2'b11, 32'h10, 32'h0, rd, er, lat);
        testsRun++;
        if (rd !== 32'h1234BEEF) begin testsFailed++; $display("FAIL rmw_reset_mem: got %h expected 1234beef", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        logic [31:0] expd  [3];
        logic [31:0] got   [3];
        int          rspEdge [3];
        logic        e;
        int          l, edgeN, seen, nextReq;
        logic [31:0] rd; logic er; int lat;
        bit          presenting;
        addrs = '{32'h10, 32'h12, 32'h13};
        sizes = '{2'b11, 2'b01, 2'b00};
        for (int i = 0; i < 3; i++) model_access(1'b0, sizes[i], addrs[i], 32'h0, expd[i], e, l);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_size  = sizes[0];
        bus.req_addr  = addrs[0];
        nextReq = 1;
        edgeN   = 0;
        seen    = 0;
        presenting = 1'b0;
        @(posedge clk); #1;
        // While busy, offer a word store to the same word; it must be ignored.
        bus.req_wr = 1'b1; bus.req_size = 2'b11; bus.req_addr = 32'h10; bus.req_wdata = $urandom;
        while (seen < 3 && edgeN < 40) begin
            @(posedge clk); #1;
            edgeN++;
            if (presenting) begin
                presenting = 1'b0;
                bus.req_wr = 1'b1; bus.req_size = 2'b11; bus.req_addr = 32'h10; bus.req_wdata = $urandom;
            end
            if (bus.rsp_valid === 1'b1) begin
                rspEdge[seen] = edgeN;
                got[seen]     = bus.rsp_rdata;
                seen++;
                testsRun++;
                if (bus.req_ready !== 1'b1) begin testsFailed++; $display("FAIL b2b_ready: got %b expected 1", bus.req_ready); end
                if (nextReq < 3) begin
                    bus.req_wr   = 1'b0;
                    bus.req_size = sizes[nextReq];
                    bus.req_addr = addrs[nextReq];
                    nextReq++;
                    presenting = 1'b1;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            testsRun++;
            if (i >= seen || rspEdge[i] != (i + 1) * LAT + i || got[i] !== expd[i]) begin
                testsFailed++;
                $display("FAIL b2b_rsp%0d: got edge=%0d rdata=%h expected edge=%0d rdata=%h", i, rspEdge[i], got[i], (i + 1) * LAT + i, expd[i]);
            end
        end
        do_req(1'b0, 2'b11, 32'h10, 32'h0, rd, er, lat);
        testsRun++;
        if (rd !== model[4]) begin testsFailed++; $display("FAIL b2b_ignored_store: got %h expected %h", rd, model[4]); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr, wd;
        logic er, eer, wr;
        logic [1:0] sz;
        int lat, elat;
        for (int w = 0; w < WINDOW; w++) begin
            wd = $urandom;
            model_access(1'b1, 2'b11, 32'(w * 4), wd, erd, eer, elat);
            do_req(1'b1, 2'b11, 32'(w * 4), wd, rd, er, lat);
            testsRun++;
            if (lat !== elat || er !== 1'b0) begin
                testsFailed++; $display("FAIL init_store%0d: got lat=%0d err=%b expected lat=%0d err=0", w, lat, er, elat);
            end
        end
        for (int n = 0; n < 200; n++) begin
            wr   = 1'($urandom_range(1));
            sz   = 2'($urandom_range(3));
            addr = 32'($urandom_range(WINDOW * 4 - 1));
            if ($urandom_range(3) == 0) addr = addr | (32'($urandom_range(15)) << 12);
            wd   = $urandom;
            model_access(wr, sz, addr, wd, erd, eer, elat);
            do_req(wr, sz, addr, wd, rd, er, lat);
            testsRun++;
            if (lat !== elat || er !== eer || (!eer && rd !== erd) || bus.req_ready !== 1'b1) begin
                testsFailed++;
                $display("FAIL rand%0d wr=%b size=%b addr=%h: got lat=%0d err=%b rdata=%h ready=%b expected lat=%0d err=%b rdata=%h ready=1",
                         n, wr, sz, addr, lat, er, rd, bus.req_ready, elat, eer, erd);
            end
            if ($urandom_range(2) == 0) begin
                @(posedge clk); #1;
                testsRun++;
                if (bus.rsp_valid !== 1'b0 || (!eer && bus.rsp_rdata !== erd)) begin
                    testsFailed++;
                    $display("FAIL rand%0d_hold: got valid=%b rdata=%h expected valid=0 rdata=%h", n, bus.rsp_valid, bus.rsp_rdata, erd);
                end
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        test_reset();
        test_word_roundtrip();
        test_byte_rmw();
        test_half_lanes();
        test_misaligned();
        test_reset_mid_rmw();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
